fetch_sequencer: RTL and testbench

Fetch/decode sequencer for the 10-bit MCU core. It owns the program counter and walks every instruction through address, memory read, instruction-register load, decode and execute. It drives the instruction register's load strobe, the instruction memory request and the execute-unit start, and resolves jumps, conditional branches and halt locally. It sits between instruction memory, the instruction register and the ALU/execute path.

---
 rtl/fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_sequencer.sv | 95 +++++++++
 tb/tb_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/decode sequencer:
// opcode constants, state encoding and default widths.
package fetch_sequencer_pkg;

    localparam int WORD_SIZE    = 10;
    localparam int ADDRESS_SIZE = 8;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_JMP = 2'b01;
    localparam logic [1:0] OP_BZ  = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter owner: walks each instruction through
// fetch, IR load, decode and execute; resolves JMP/BZ/HLT.
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
    parameter int word_size    = WORD_SIZE,
    parameter int address_size = ADDRESS_SIZE,
    parameter logic [address_size-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic                    mem_req,
    output logic [address_size-1:0] mem_addr,
    input  logic                    mem_ack,
    output logic                    ir_load,
    input  logic [word_size-1:0]    ir_q,
    input  logic                    zero_flag,
    output logic                    exec_start,
    input  logic                    exec_done,
    output logic [address_size-1:0] pc,
    output logic                    halted
);

    state_t                  state;
    state_t                  state_next;
    logic [address_size-1:0] pc_next;
    logic [1:0]              opcode;
    logic [address_size-1:0] operand;

    assign opcode  = ir_q[word_size-1:word_size-2];
    assign operand = ir_q[address_size-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // exec_start decodes the IR register output, never a raw input
    always_comb begin
        state_next = state;
        pc_next    = pc;
        exec_start = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) state_next = S_LOAD;
            end
            S_LOAD: begin
                pc_next    = pc + address_size'(1);
                state_next = S_DECODE;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_ALU: begin
                        exec_start = 1'b1;
                        state_next = S_EXEC;
                    end
                    OP_JMP: begin
                        pc_next    = operand;
                        state_next = S_IDLE;
                    end
                    OP_BZ: begin
                        if (zero_flag) pc_next = operand;
                        state_next = S_IDLE;
                    end
                    OP_HLT: begin
                        state_next = S_HALT;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
            S_EXEC: begin
                if (exec_done) state_next = S_IDLE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign mem_req  = (state == S_FETCH);
    assign mem_addr = pc;
    assign ir_load  = (state == S_LOAD);
    assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer with a
// per-instruction timeline model of the sequencer.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic       ir_load;
    logic [9:0] ir_q;
    logic       zero_flag;
    logic       exec_start;
    logic       exec_done;
    logic [7:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .ir_load    (ir_load),
        .ir_q       (ir_q),
        .zero_flag  (zero_flag),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One instruction from IDLE back to IDLE (or HALT).
    // ad: mem_ack wait cycles; dd: cycles from exec_start to exec_done.
    // abort_at: cycle index at which rst is pulsed (-1 for none).
    task automatic do_instr(input string nm, input logic [9:0] instr,
                            input logic zf, input int ad, input int dd,
                            input int abort_at);
        logic [1:0] op;
        logic [7:0] opnd;
        logic [7:0] pc_a;
        logic [7:0] pc_b;
        logic [7:0] pc_c;
        logic [7:0] want_pc;
        logic [3:0] got;
        logic [3:0] want;
        bit         is_alu;
        int         d;
        int         n;
        op     = instr[9:8];
        opnd   = instr[7:0];
        is_alu = (op == 2'b00);
        d      = 3 + ad;
        n      = is_alu ? d + dd + 1 : d + 1;
        pc_a   = exp_pc;
        pc_b   = 8'((int'(pc_a) + 1) % 256);
        pc_c   = (op == 2'b01 || (op == 2'b10 && zf)) ? opnd : pc_b;
        for (int s = 0; s < n; s++) begin
            run = (s == 0) ? 1'b1 : 1'($urandom);
            if (s >= 1 && s <= ad) mem_ack = 1'b0;
            else if (s == 1 + ad) mem_ack = 1'b1;
            else mem_ack = 1'($urandom);
            if (is_alu && s > d && s < d + dd) exec_done = 1'b0;
            else if (is_alu && s == d + dd) exec_done = 1'b1;
            else exec_done = 1'($urandom);
            ir_q      = (s >= d) ? instr : 10'($urandom);
            zero_flag = (s == d) ? zf : 1'($urandom);
            #1;
            got  = {mem_req, ir_load, exec_start, halted};
            want = {(s >= 1 && s <= 1 + ad), (s == 2 + ad),
                    (is_alu && s == d), 1'b0};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s ctrl cyc=%0d got %b want %b",
                         nm, s, got, want);
            end
            if (s <= 2 + ad) want_pc = pc_a;
            else if (s == d) want_pc = pc_b;
            else want_pc = pc_c;
            checks++;
            if (pc !== want_pc) begin
                errors++;
                $display("FAIL %s pc cyc=%0d got %h want %h",
                         nm, s, pc, want_pc);
            end
            if (want[3]) begin
                checks++;
                if (mem_addr !== pc_a) begin
                    errors++;
                    $display("FAIL %s mem_addr cyc=%0d got %h want %h",
                             nm, s, mem_addr, pc_a);
                end
            end
            if (s == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                run = 1'b0;
                got = {mem_req, ir_load, exec_start, halted};
                checks++;
                if (got !== 4'b0000 || pc !== 8'h00) begin
                    errors++;
                    $display("FAIL %s abort got %b pc %h want 0000 pc 00",
                             nm, got, pc);
                end
                exp_pc = 8'h00;
                return;
            end
            tick();
        end
        run       = 1'b0;
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        #1;
        got  = {mem_req, ir_load, exec_start, halted};
        want = {3'b000, op == 2'b11};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s end ctrl got %b want %b", nm, got, want);
        end
        checks++;
        if (pc !== pc_c) begin
            errors++;
            $display("FAIL %s end pc got %h want %h", nm, pc, pc_c);
        end
        exp_pc = pc_c;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        run       = 1'b1;
        mem_ack   = 1'b1;
        exec_done = 1'b1;
        ir_q      = 10'h3ff;
        zero_flag = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mem_req, ir_load, exec_start, halted} !== 4'b0000
            || pc !== 8'h00) begin
            errors++;
            $display("FAIL reset got %b pc %h want 0000 pc 00",
                     {mem_req, ir_load, exec_start, halted}, pc);
        end
        rst       = 1'b0;
        run       = 1'b0;
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL idle_hold got req %b pc %h want 0 00",
                     mem_req, pc);
        end
        exp_pc = 8'h00;
    endtask

    task automatic test_alu_basic;
        do_instr("alu_basic", 10'b00_00000011, 1'b0, 0, 2, -1);
    endtask

    task automatic test_jmp;
        do_instr("jmp", 10'b01_10100000, 1'b0, 0, 1, -1);
        do_instr("after_jmp", 10'b00_00000001, 1'b0, 0, 1, -1);
    endtask

    task automatic test_bz;
        do_instr("bz_nt", 10'b10_01000000, 1'b0, 0, 1, -1);
        do_instr("bz_t", 10'b10_01000000, 1'b1, 0, 1, -1);
    endtask

    task automatic test_wrap;
        do_instr("jmp_ff", 10'b01_11111111, 1'b0, 0, 1, -1);
        do_instr("wrap", 10'b00_00000101, 1'b0, 0, 1, -1);
    endtask

    task automatic test_mem_wait;
        do_instr("mem_wait", 10'b00_00010000, 1'b0, 3, 1, -1);
    endtask

    task automatic test_random;
        logic [9:0] w;
        for (int i = 0; i < 40; i++) begin
            w = {2'($urandom_range(0, 2)), 8'($urandom)};
            do_instr("random", w, 1'($urandom),
                     int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 3)), -1);
        end
    endtask

    task automatic test_halt;
        do_instr("hlt", 10'b11_00000000, 1'b0, 1, 1, -1);
        for (int i = 0; i < 8; i++) begin
            run       = 1'($urandom);
            mem_ack   = 1'($urandom);
            exec_done = 1'($urandom);
            tick();
            checks++;
            if ({mem_req, ir_load, exec_start, halted} !== 4'b0001
                || pc !== exp_pc) begin
                errors++;
                $display("FAIL halt_hold got %b pc %h want 0001 pc %h",
                         {mem_req, ir_load, exec_start, halted},
                         pc, exp_pc);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b0;
        checks++;
        if ({mem_req, ir_load, exec_start, halted} !== 4'b0000
            || pc !== 8'h00) begin
            errors++;
            $display("FAIL halt_reset got %b pc %h want 0000 pc 00",
                     {mem_req, ir_load, exec_start, halted}, pc);
        end
        exp_pc = 8'h00;
    endtask

    task automatic test_reset_exec;
        do_instr("pre_exec", 10'b01_00110000, 1'b0, 0, 1, -1);
        do_instr("rst_exec", 10'b00_00000111, 1'b0, 1, 4, 6);
        do_instr("post_rst", 10'b00_00000010, 1'b0, 0, 1, -1);
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_jmp();
        test_bz();
        test_wrap();
        test_mem_wait();
        test_random();
        test_halt();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
